mix_term_gen: RTL and testbench
===============================

// Module: mix_term_gen
// PURPOSE
// - Feeds the 4-input XOR mix unit (in0..in3) for AES MixColumns on a row-major state.
// - Buffers the four 32-bit state rows, then emits four term sets, one per output row r.
// - Each term set is {2*a[r], 3*a[r+1], a[r+2], a[r+3]} (GF(2^8), indices mod 4), computed per byte lane.
// - The downstream XOR of term0..term3 yields output row r.
// PARAMETERS
// - DATA_W  32     state row width; multiple of 8; LANES = DATA_W/8 independent byte lanes
// - POLY    8'h1B  reduction byte for xtime (x^8 + POLY)
// PORTS
// - clk        in   1       clock; all state updates on its rising edge
// - rst        in   1       synchronous reset, active-high
// - run        in   1       1-cycle pulse; starts (or restarts) a new 4-row block
// - in_valid   in   1       row word valid
// - in_ready   out  1       row word accepted when in_valid & in_ready
// - in_data    in   DATA_W  state row; lane j = bits [8j+7:8j]
// - out_valid  out  1       term set valid
// - out_ready  in   1       term set consumed when out_valid & out_ready
// - term0..3   out  DATA_W  registered terms; connect to in0..in3 of the XOR mix unit
// - out_row    out  2       output row index r of the current term set
// - out_last   out  1       high with the r==3 term set
// - busy       out  1       high when state != IDLE
// - done       out  1       1-cycle pulse, the cycle after the r==3 set is consumed
// BEHAVIOUR
// - Reset: state IDLE, counter 0, in_ready=0, out_valid=0, term0..3=0, out_row=0,
//   out_last=0, busy=0, done=0, row buffer cleared.
// - FSM states: IDLE, LOAD, EMIT.
// - IDLE: run -> LOAD, cnt=0. in_ready=0 and out_valid=0 in IDLE.
// - LOAD: in_ready=1. Each accepted word is written to row_buf[cnt] and cnt increments.
//   The 4th accept -> EMIT, cnt=0, and the r=0 terms are registered.
// - Latency: out_valid rises the cycle after the 4th input accept.
// - EMIT: in_ready=0, out_valid=1.
//   On a consume with r<3: the r+1 terms are registered the same edge, so back-to-back beats sustain 1 set/cycle.
//   On a consume with r==3: -> IDLE, out_valid=0, done=1 for the next cycle.
// - Backpressure: while out_valid & ~out_ready, term0..3, out_row and out_last are held stable.
// - xtime(b) = (b<<1)[7:0] ^ (b[7] ? POLY : 0).
// - 3*b = xtime(b) ^ b.
// - No carries cross byte lanes.
// - run in LOAD or EMIT aborts the block:
//   next cycle state=LOAD, cnt=0, out_valid=0, no done pulse, row buffer contents don't-care.
// - run has priority over a same-cycle in/out handshake; that beat is discarded.
// - rst wins over run and all handshakes. rst mid-operation returns to the reset values next cycle.
// - in_valid outside LOAD is ignored. out_ready outside EMIT is ignored.
// CONFIGURATION
// - MIX_INV_EN defined: adds input port inv (1 bit), sampled on the run pulse and held for the block.
//   - inv=1 emits InvMixColumns terms {0E*a[r], 0B*a[r+1], 0D*a[r+2], 09*a[r+3]}, built from chained xtime.
//   - inv=0 emits the forward terms.
// - MIX_INV_EN undefined: no inv port; forward terms only.
// TESTING
// - Forward vector: run; rows 0x000000DB, 0x00000013, 0x00000053, 0x00000045; out_ready=1.
//   -> r0 terms = 0xAD, 0x35, 0x53, 0x45 (XOR 0x8E).
//   -> r1..r3 XORs = 0x4D, 0xA1, 0xBC.
//   -> out_last on r3; done pulses 1 cycle after the r3 consume.
// - All-FF lanes: four rows of 0xFFFFFFFF.
//   -> every set = {0xE5E5E5E5, 0x1A1A1A1A, 0xFFFFFFFF, 0xFFFFFFFF}.
//   -> XOR = 0xFFFFFFFF; out_row steps 0,1,2,3.
// - Backpressure: forward vector with out_ready low for 3 cycles at r=1.
//   -> terms and out_row held.
//   -> r1..r3 XORs still 0x4D, 0xA1, 0xBC.
// - Abort: run pulsed during EMIT r=2.
//   -> next cycle LOAD, out_valid=0, no done.
//   -> a new all-FF block then completes correctly.
// - Reset mid-LOAD: rst after 2 rows accepted.
//   -> IDLE, busy=0, in_ready=0; a subsequent run and 4 rows complete normally.
// - MIX_INV_EN build: inv=1, rows 0x8E, 0x4D, 0xA1, 0xBC in lane 0.
//   -> per-row XORs 0xDB, 0x13, 0x53, 0x45.
//   -> inv=0 in the same build reproduces the forward vector.

Source files
------------

// File: rtl/mix_term_gen.sv
// mix_term_gen
// Buffers four row-major AES state rows and then emits, for each output row r,
// the four MixColumns terms {2*a[r], 3*a[r+1], a[r+2], a[r+3]}. Every byte lane
// is computed on its own in GF(2^8). The downstream 4-input XOR of term0..term3
// forms output row r.
//
// Optional build macro: MIX_INV_EN
//   When it is defined, an extra input `inv` is sampled on each run pulse and
//   held for the whole block. With inv=1 the block emits the InvMixColumns terms
//   {0E*a[r], 0B*a[r+1], 0D*a[r+2], 09*a[r+3]}.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   run                 one-cycle pulse that starts or restarts a 4-row block
//   in_valid/in_ready   row-word handshake; in_data lane j = bits [8j+7:8j]
//   out_valid/out_ready term-set handshake
//   term0..term3        registered terms for the XOR mix unit
//   out_row, out_last   row index of the current set; out_last is high for r==3
//   busy, done          busy when not idle; done pulses after the r==3 set is consumed
module mix_term_gen #(
    parameter int         DATA_W = 32,
    parameter logic [7:0] POLY   = 8'h1B
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
`ifdef MIX_INV_EN
    input  logic              inv,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] term0,
    output logic [DATA_W-1:0] term1,
    output logic [DATA_W-1:0] term2,
    output logic [DATA_W-1:0] term3,
    output logic [1:0]        out_row,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int LANES = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Multiply by x modulo (x^8 + POLY).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
    endfunction

    // Scale every byte lane of a row by a small constant taken from the xtime chain.
    function automatic logic [DATA_W-1:0] row_mul(input logic [DATA_W-1:0] row,
                                                  input logic [3:0]        coef);
        logic [DATA_W-1:0] res;
        logic [7:0]        b;
        logic [7:0]        x2;
        logic [7:0]        x4;
        logic [7:0]        x8;
        res = {DATA_W{1'b0}};
        for (int j = 0; j < LANES; j++) begin
            b  = row[8*j +: 8];
            x2 = xtime(b);
            x4 = xtime(x2);
            x8 = xtime(x4);
            case (coef)
                4'h1:    res[8*j +: 8] = b;
                4'h2:    res[8*j +: 8] = x2;
                4'h3:    res[8*j +: 8] = x2 ^ b;
                4'h9:    res[8*j +: 8] = x8 ^ b;
                4'hB:    res[8*j +: 8] = x8 ^ x2 ^ b;
                4'hD:    res[8*j +: 8] = x8 ^ x4 ^ b;
                4'hE:    res[8*j +: 8] = x8 ^ x4 ^ x2;
                default: res[8*j +: 8] = 8'h00;
            endcase
        end
        return res;
    endfunction

    // Build the packed term set {t3,t2,t1,t0} for output row r from the four buffered rows.
    function automatic logic [4*DATA_W-1:0] term_set(input logic [4*DATA_W-1:0] rows,
                                                     input logic [1:0]          r,
                                                     input logic                inv_sel);
        logic [4*DATA_W-1:0] res;
        logic [1:0]          kk;
        logic [1:0]          idx;
        logic [3:0]          coef;
        res = {(4*DATA_W){1'b0}};
        for (int k = 0; k < 4; k++) begin
            kk  = 2'(k);
            idx = r + kk;                 // wraps mod 4
            case (kk)
                2'd0:    coef = inv_sel ? 4'hE : 4'h2;
                2'd1:    coef = inv_sel ? 4'hB : 4'h3;
                2'd2:    coef = inv_sel ? 4'hD : 4'h1;
                default: coef = inv_sel ? 4'h9 : 4'h1;
            endcase
            res[k*DATA_W +: DATA_W] = row_mul(rows[idx*DATA_W +: DATA_W], coef);
        end
        return res;
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [1:0]          cnt_r;
    logic [1:0]          cnt_s;
    logic [4*DATA_W-1:0] row_buf_r;
    logic [4*DATA_W-1:0] row_buf_s;
    logic [4*DATA_W-1:0] rows_fill_s;
    logic [4*DATA_W-1:0] terms_r;
    logic [4*DATA_W-1:0] terms_s;
    logic [1:0]          out_row_r;
    logic [1:0]          out_row_s;
    logic                out_last_r;
    logic                out_last_s;
    logic                done_r;
    logic                done_s;
    logic                in_ready_r;
    logic                out_valid_r;
    logic                busy_r;
    logic                inv_sel_s;

`ifdef MIX_INV_EN
    logic inv_r;
    logic inv_s;

    // Capture the transform direction on each run pulse and hold it for the block.
    always_comb begin
        inv_s = inv_r;
        if (run) begin
            inv_s = inv;
        end else begin
            inv_s = inv_r;
        end
        inv_sel_s = inv_r;
    end

    // Direction register.
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_r <= 1'b0;
        end else begin
            inv_r <= inv_s;
        end
    end
`else
    // Forward-only build: direction is fixed.
    always_comb begin
        inv_sel_s = 1'b0;
    end
`endif

    // The 4th word is still on in_data when the r=0 terms are built, so splice it in as row 3.
    always_comb begin
        rows_fill_s = {in_data, row_buf_r[3*DATA_W-1:0]};
    end

    // Next-state, buffer and term-register logic; run takes priority over any handshake.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        row_buf_s  = row_buf_r;
        terms_s    = terms_r;
        out_row_s  = out_row_r;
        out_last_s = out_last_r;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (run) begin
                    state_s = LOAD;
                    cnt_s   = 2'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (run) begin
                    state_s = LOAD;
                    cnt_s   = 2'd0;
                end else if (in_valid) begin
                    row_buf_s[cnt_r*DATA_W +: DATA_W] = in_data;
                    if (cnt_r == 2'd3) begin
                        state_s    = EMIT;
                        cnt_s      = 2'd0;
                        terms_s    = term_set(rows_fill_s, 2'd0, inv_sel_s);
                        out_row_s  = 2'd0;
                        out_last_s = 1'b0;
                    end else begin
                        cnt_s = cnt_r + 2'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            EMIT: begin
                if (run) begin
                    state_s = LOAD;
                    cnt_s   = 2'd0;
                end else if (out_ready) begin
                    if (out_row_r == 2'd3) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        // Next set is registered on the consuming edge for 1 set/cycle.
                        terms_s    = term_set(row_buf_r, out_row_r + 2'd1, inv_sel_s);
                        out_row_s  = out_row_r + 2'd1;
                        out_last_s = (out_row_r == 2'd2);
                    end
                end else begin
                    state_s = EMIT;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 2'd0;
            end
        endcase
    end

    // State, buffer and registered outputs; handshake flags follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 2'd0;
            row_buf_r   <= {(4*DATA_W){1'b0}};
            terms_r     <= {(4*DATA_W){1'b0}};
            out_row_r   <= 2'd0;
            out_last_r  <= 1'b0;
            done_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            row_buf_r   <= row_buf_s;
            terms_r     <= terms_s;
            out_row_r   <= out_row_s;
            out_last_r  <= out_last_s;
            done_r      <= done_s;
            in_ready_r  <= (state_s == LOAD);
            out_valid_r <= (state_s == EMIT);
            busy_r      <= (state_s != IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign term0     = terms_r[0*DATA_W +: DATA_W];
    assign term1     = terms_r[1*DATA_W +: DATA_W];
    assign term2     = terms_r[2*DATA_W +: DATA_W];
    assign term3     = terms_r[3*DATA_W +: DATA_W];
    assign out_row   = out_row_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_mix_term_gen.sv
// Scoreboard bench for mix_term_gen: the driver pushes expected term sets when a
// block is loaded, and a negedge monitor compares and pops them on every handshake.
module tb_mix_term_gen;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  term0;
    logic [W-1:0]  term1;
    logic [W-1:0]  term2;
    logic [W-1:0]  term3;
    logic [1:0]    out_row;
    logic          out_last;
    logic          busy;
    logic          done;
`ifdef MIX_INV_EN
    logic          inv = 1'b0;
`endif

    mix_term_gen #(.DATA_W(W), .POLY(8'h1B)) dut (
        .clk(clk), .rst(rst), .run(run),
`ifdef MIX_INV_EN
        .inv(inv),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .term0(term0), .term1(term1), .term2(term2), .term3(term3),
        .out_row(out_row), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] t0;
        logic [31:0] t1;
        logic [31:0] t2;
        logic [31:0] t3;
        logic [1:0]  row;
        logic        last;
    } exp_t;

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    exp_t        exp_q[$];
    logic [31:0] xor_q[$];
    bit          exp_done = 1'b0;
    bit          mon_en = 1'b0;

    // Plain shift-and-add GF(2^8) multiply with the AES polynomial.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] row_scale(input logic [31:0] row, input logic [7:0] c);
        logic [31:0] r = 32'h0;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = gf_mul(row[8*j +: 8], c);
        return r;
    endfunction

    function automatic void push_block(input logic [127:0] rows);
        exp_t e;
        for (int r = 0; r < 4; r++) begin
            e.t0   = row_scale(rows[32*r +: 32], 8'h02);
            e.t1   = row_scale(rows[32*((r+1)%4) +: 32], 8'h03);
            e.t2   = rows[32*((r+2)%4) +: 32];
            e.t3   = rows[32*((r+3)%4) +: 32];
            e.row  = 2'(r);
            e.last = (r == 3);
            exp_q.push_back(e);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: done timing, output latency, term/row/last against the queue head, pop on handshake.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("done", 32'(done), 32'(exp_done));
            exp_done = 1'b0;
            if (exp_q.size() > 0) check("out_valid_present", 32'(out_valid), 32'd1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("term0", term0, exp_q[0].t0);
                    check("term1", term1, exp_q[0].t1);
                    check("term2", term2, exp_q[0].t2);
                    check("term3", term3, exp_q[0].t3);
                    check("out_row", 32'(out_row), 32'(exp_q[0].row));
                    check("out_last", 32'(out_last), 32'(exp_q[0].last));
                    if (out_ready && !run) begin
                        if (xor_q.size() > 0) begin
                            check("row_xor", term0 ^ term1 ^ term2 ^ term3, xor_q[0]);
                            void'(xor_q.pop_front());
                        end
                        if (exp_q[0].last) exp_done = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [127:0] rows, input bit do_run, input int n, input bit gaps);
        int i = 0;
        int guard = 0;
        bit fire;
        if (do_run) begin
            run = 1'b1;
            tick();
            run = 1'b0;
        end
        while (i < n && guard < 200) begin
            in_valid = gaps ? ($urandom % 4 != 0) : 1'b1;
            in_data  = rows[32*i +: 32];
            fire     = in_valid && in_ready;
            tick();
            if (fire) i++;
            guard++;
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        if (guard >= 200) check("load_timeout", 32'(i), 32'(n));
        if (n == 4 && i == 4) push_block(rows);
    endtask

    task automatic drain(input bit rnd, input int hold_r1);
        int guard = 0;
        int h = hold_r1;
        while (exp_q.size() > 0 && guard < 300) begin
            if (h > 0 && out_valid && out_row == 2'd1) begin
                out_ready = 1'b0;
                h--;
            end else begin
                out_ready = rnd ? 1'($urandom % 2) : 1'b1;
            end
            tick();
            guard++;
        end
        out_ready = 1'b0;
        if (guard >= 300) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
    endtask

    task automatic push_fwd_xors();
        xor_q.push_back(32'h0000008E);
        xor_q.push_back(32'h0000004D);
        xor_q.push_back(32'h000000A1);
        xor_q.push_back(32'h000000BC);
    endtask

    logic [127:0] fwd_rows;
    logic [127:0] ff_rows;
    logic [127:0] rnd_rows;

    initial begin
        fwd_rows = {32'h00000045, 32'h00000053, 32'h00000013, 32'h000000DB};
        ff_rows  = {4{32'hFFFFFFFF}};
        rst = 1'b1; run = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_terms", term0 | term1 | term2 | term3, 32'd0);
        check("rst_out_row", 32'(out_row), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Forward vector.
        push_fwd_xors();
        send_block(fwd_rows, 1'b1, 4, 1'b0);
        drain(1'b0, 0);
        check("idle_after_block", 32'(busy), 32'd0);

        // All-FF lanes.
        repeat (4) xor_q.push_back(32'hFFFFFFFF);
        send_block(ff_rows, 1'b1, 4, 1'b0);
        drain(1'b0, 0);

        // Backpressure at r=1.
        push_fwd_xors();
        send_block(fwd_rows, 1'b1, 4, 1'b0);
        drain(1'b0, 3);

        // Abort during EMIT r=2, then a fresh all-FF block without a new run.
        push_fwd_xors();
        send_block(fwd_rows, 1'b1, 4, 1'b0);
        out_ready = 1'b1;
        for (int g = 0; g < 20 && !(out_valid && out_row == 2'd2); g++) tick();
        check("abort_reached_r2", 32'(out_row), 32'd2);
        run = 1'b1;
        tick();
        run = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        xor_q.delete();
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        repeat (4) xor_q.push_back(32'hFFFFFFFF);
        send_block(ff_rows, 1'b0, 4, 1'b0);
        drain(1'b0, 0);

        // Reset after two rows accepted.
        rnd_rows = {$urandom, $urandom, $urandom, $urandom};
        send_block(rnd_rows, 1'b1, 2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd0);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        send_block(rnd_rows, 1'b1, 4, 1'b0);
        drain(1'b0, 0);

        // Random blocks with input gaps and random backpressure.
        for (int b = 0; b < 8; b++) begin
            rnd_rows = {$urandom, $urandom, $urandom, $urandom};
            send_block(rnd_rows, 1'b1, 4, 1'b1);
            drain(1'b1, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
